// File: rtl/uio_arb_pkg.sv
// Shared types and constants for the uio pin-bank arbiter.
package uio_arb_pkg;

    typedef enum logic [1:0] {StIdle, StTurn, StOwn} arb_state_e;

    localparam logic DIR_IN  = 1'b0;
    localparam logic DIR_OUT = 1'b1;

    localparam int unsigned HOLD_W = 4;
    localparam int unsigned TURN_W = 2;

endpackage

// File: rtl/uio_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_pick
    import uio_arb_pkg::*;
#(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned PTR_W = 2
) (
    input  logic [NREQ-1:0]  req,
    input  logic [PTR_W-1:0] ptr,
    output logic [NREQ-1:0]  pick,
    output logic             any
);

    always_comb begin
        pick = '0;
        any  = 1'b0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            if (!any && req[(int'(ptr) + k) % NREQ]) begin
                pick[(int'(ptr) + k) % NREQ] = 1'b1;
                any                           = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uio_arbiter.sv
// Round-robin owner of the shared uio pin bank with turnaround insertion and
// bounded tenure per grant.
module uio_arbiter
    import uio_arb_pkg::*;
#(
    parameter int unsigned NREQ     = 4,
    parameter int unsigned MAX_HOLD = 8,
    parameter int unsigned TURN     = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ena,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ-1:0]   dir,
    input  logic [NREQ-1:0]   last,
    input  logic [NREQ*8-1:0] wdata,
    output logic [NREQ-1:0]   gnt,
    output logic [7:0]        rdata,
    output logic              rvalid,
    output logic              busy,
    input  logic [7:0]        uio_in,
    output logic [7:0]        uio_out,
    output logic [7:0]        uio_oe
);

    localparam int unsigned PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [PTR_W-1:0]  LAST_IDX   = PTR_W'(NREQ - 1);
    localparam logic [HOLD_W-1:0] MAX_HOLD_C = HOLD_W'(MAX_HOLD);
    localparam logic [TURN_W-1:0] TURN_LOAD  = TURN_W'(TURN - 1);

    arb_state_e        state_q, state_d;
    logic [PTR_W-1:0]  win_q, win_d;
    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [TURN_W-1:0] turn_q, turn_d;
    logic              bus_dir_q, bus_dir_d;
    logic [7:0]        out_q, out_d;
    logic [7:0]        oe_q, oe_d;
    logic [7:0]        rdata_q, rdata_d;
    logic              rvalid_q, rvalid_d;

    logic [NREQ-1:0]   pick;
    logic              any;
    logic [PTR_W-1:0]  pick_idx;
    logic [PTR_W-1:0]  win_next;
    logic [HOLD_W-1:0] hold_inc;

    rr_pick #(
        .NREQ  (NREQ),
        .PTR_W (PTR_W)
    ) u_rr_pick (
        .req  (req),
        .ptr  (ptr_q),
        .pick (pick),
        .any  (any)
    );

    always_comb begin
        pick_idx = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (pick[i]) pick_idx = PTR_W'(i);
        end
    end

    assign win_next = (win_q == LAST_IDX) ? '0 : win_q + 1'b1;
    assign hold_inc = hold_q + 1'b1;

    always_comb begin
        state_d   = state_q;
        win_d     = win_q;
        ptr_d     = ptr_q;
        hold_d    = hold_q;
        turn_d    = turn_q;
        bus_dir_d = bus_dir_q;
        out_d     = out_q;
        oe_d      = oe_q;
        rdata_d   = rdata_q;
        rvalid_d  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (ena && any) begin
                    win_d = pick_idx;
                    if (dir[pick_idx] == bus_dir_q) begin
                        state_d = StOwn;
                        if (bus_dir_q == DIR_OUT) oe_d = 8'hFF;
                    end else begin
                        state_d = StTurn;
                        turn_d  = TURN_LOAD;
                        oe_d    = 8'h00;
                    end
                end
            end
            StTurn: begin
                if (turn_q == '0) begin
                    state_d   = StOwn;
                    bus_dir_d = dir[win_q];
                    if (dir[win_q] == DIR_OUT) oe_d = 8'hFF;
                end else begin
                    turn_d = turn_q - 1'b1;
                end
            end
            StOwn: begin
                if (!req[win_q]) begin
                    state_d = StIdle;
                    ptr_d   = win_next;
                    hold_d  = '0;
                end else begin
                    hold_d = hold_inc;
                    if (bus_dir_q == DIR_OUT) begin
                        out_d = wdata[8*int'(win_q) +: 8];
                    end else begin
                        rdata_d  = uio_in;
                        rvalid_d = 1'b1;
                    end
                    if (last[win_q] || hold_inc == MAX_HOLD_C) begin
                        state_d = StIdle;
                        ptr_d   = win_next;
                        hold_d  = '0;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        // Disable overrides everything: no beat effects, pins back to input.
        if (!ena) begin
            state_d   = StIdle;
            ptr_d     = (state_q == StOwn) ? win_next : ptr_q;
            hold_d    = '0;
            bus_dir_d = DIR_IN;
            oe_d      = 8'h00;
            out_d     = out_q;
            rdata_d   = rdata_q;
            rvalid_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            win_q     <= '0;
            ptr_q     <= '0;
            hold_q    <= '0;
            turn_q    <= '0;
            bus_dir_q <= DIR_IN;
            out_q     <= 8'h00;
            oe_q      <= 8'h00;
            rdata_q   <= 8'h00;
            rvalid_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            win_q     <= win_d;
            ptr_q     <= ptr_d;
            hold_q    <= hold_d;
            turn_q    <= turn_d;
            bus_dir_q <= bus_dir_d;
            out_q     <= out_d;
            oe_q      <= oe_d;
            rdata_q   <= rdata_d;
            rvalid_q  <= rvalid_d;
        end
    end

    always_comb begin
        gnt = '0;
        if (state_q == StOwn) gnt[win_q] = 1'b1;
    end

    assign busy    = (state_q != StIdle);
    assign uio_out = out_q;
    assign uio_oe  = oe_q;
    assign rdata   = rdata_q;
    assign rvalid  = rvalid_q;

endmodule

// File: tb/tb_uio_arbiter.sv
// Directed and randomized checks of uio_arbiter against a transaction-level
// model of ownership, turnaround and pin state.
module tb_uio_arbiter;

    localparam int NREQ     = 4;
    localparam int MAX_HOLD = 8;
    localparam int TURN     = 1;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              ena = 1'b0;
    logic [NREQ-1:0]   req = '0;
    logic [NREQ-1:0]   dir = '0;
    logic [NREQ-1:0]   last = '0;
    logic [NREQ*8-1:0] wdata = '0;
    logic [7:0]        uio_in = '0;
    logic [NREQ-1:0]   gnt;
    logic [7:0]        rdata;
    logic              rvalid;
    logic              busy;
    logic [7:0]        uio_out;
    logic [7:0]        uio_oe;

    int checks = 0;
    int errors = 0;

    uio_arbiter #(
        .NREQ     (NREQ),
        .MAX_HOLD (MAX_HOLD),
        .TURN     (TURN)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .ena     (ena),
        .req     (req),
        .dir     (dir),
        .last    (last),
        .wdata   (wdata),
        .gnt     (gnt),
        .rdata   (rdata),
        .rvalid  (rvalid),
        .busy    (busy),
        .uio_in  (uio_in),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    always #5 clk = ~clk;

    // Model: who owns the bus, who is waiting out a turnaround, and pin state.
    int         m_owner = -1;
    int         m_waiter = -1;
    int         m_wait = 0;
    int         m_beats = 0;
    int         m_ptr = 0;
    bit         m_bus_out = 1'b0;
    logic [7:0] m_oe = 8'h00;
    logic [7:0] m_out = 8'h00;
    logic [7:0] m_rd = 8'h00;
    bit         m_rv = 1'b0;

    task automatic model_reset();
        m_owner = -1; m_waiter = -1; m_wait = 0; m_beats = 0; m_ptr = 0;
        m_bus_out = 1'b0; m_oe = 8'h00; m_out = 8'h00; m_rd = 8'h00; m_rv = 1'b0;
    endtask

    task automatic model_step();
        bit rv_next;
        bit done;
        int w;
        rv_next = 1'b0;
        if (rst) begin
            model_reset();
            return;
        end
        if (!ena) begin
            if (m_owner >= 0) m_ptr = (m_owner + 1) % NREQ;
            m_owner = -1; m_waiter = -1; m_beats = 0;
            m_oe = 8'h00; m_bus_out = 1'b0; m_rv = 1'b0;
            return;
        end
        if (m_owner >= 0) begin
            done = !req[m_owner];
            if (req[m_owner]) begin
                m_beats++;
                if (m_bus_out) m_out = wdata[m_owner*8 +: 8];
                else begin
                    m_rd = uio_in;
                    rv_next = 1'b1;
                end
                done = last[m_owner] || (m_beats == MAX_HOLD);
            end
            if (done) begin
                m_ptr = (m_owner + 1) % NREQ;
                m_owner = -1;
                m_beats = 0;
            end
        end else if (m_waiter >= 0) begin
            if (m_wait == 0) begin
                m_bus_out = dir[m_waiter];
                m_owner = m_waiter;
                m_waiter = -1;
                m_oe = m_bus_out ? 8'hFF : 8'h00;
            end else begin
                m_wait--;
            end
        end else if (req != 0) begin
            w = -1;
            for (int k = 0; k < NREQ; k++) begin
                if (w < 0 && req[(m_ptr + k) % NREQ]) w = (m_ptr + k) % NREQ;
            end
            if (dir[w] == m_bus_out) begin
                m_owner = w;
                if (m_bus_out) m_oe = 8'hFF;
            end else begin
                m_waiter = w;
                m_wait = TURN - 1;
                m_oe = 8'h00;
            end
        end
        m_rv = rv_next;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        logic [NREQ-1:0] g;
        g = '0;
        if (m_owner >= 0) g[m_owner] = 1'b1;
        check("gnt", 32'(gnt), 32'(g));
        check("busy", 32'(busy), 32'((m_owner >= 0) || (m_waiter >= 0)));
        check("uio_oe", 32'(uio_oe), 32'(m_oe));
        check("uio_out", 32'(uio_out), 32'(m_out));
        check("rdata", 32'(rdata), 32'(m_rd));
        check("rvalid", 32'(rvalid), 32'(m_rv));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    initial begin
        int n;
        int order [5] = '{0, 1, 2, 3, 0};

        // Reset state
        tick();
        tick();
        check("rst_gnt", 32'(gnt), 0);
        check("rst_oe", 32'(uio_oe), 0);
        rst = 1'b0;
        ena = 1'b1;

        // Single drive requester 0 (bus starts as input, so one turnaround)
        req = 4'b0001; dir = 4'b0001; wdata = 32'h0000_00A5;
        tick(); check("d1_turn_gnt", 32'(gnt), 0); check("d1_turn_busy", 32'(busy), 1);
        tick(); check("d1_gnt", 32'(gnt), 32'h1);
        tick(); check("d1_out", 32'(uio_out), 32'hA5); check("d1_oe", 32'(uio_oe), 32'hFF);
        tick();
        last = 4'b0001;
        tick(); check("d1_release", 32'(gnt), 0); check("d1_oe_held", 32'(uio_oe), 32'hFF);
        req = '0; last = '0;

        // Requester 1 samples: turnaround toward input
        req = 4'b0010; dir = 4'b0000; uio_in = 8'h3C;
        tick(); check("d2_turn_oe", 32'(uio_oe), 0); check("d2_turn_gnt", 32'(gnt), 0);
        tick(); check("d2_gnt", 32'(gnt), 32'h2);
        tick(); check("d2_rdata", 32'(rdata), 32'h3C); check("d2_rvalid", 32'(rvalid), 1);
        last = 4'b0010;
        tick(); check("d2_rvalid2", 32'(rvalid), 1);
        req = '0; last = '0;
        tick(); check("d2_rvalid_off", 32'(rvalid), 0);

        // Owner drops req with last: no beat, pointer advances to 3
        req = 4'b0100;
        tick(); check("d4_gnt", 32'(gnt), 32'h4);
        tick();
        req = '0; last = 4'b0100;
        tick(); check("d4_release", 32'(gnt), 0); check("d4_no_beat", 32'(rvalid), 0);
        last = '0; req = 4'b1111; dir = 4'b1000; wdata = 32'h1122_3344;
        tick(); check("d4_turn", 32'(gnt), 0);
        tick(); check("d4_ptr_next", 32'(gnt), 32'h8);
        tick(); check("d6_out", 32'(uio_out), 32'h11); check("d6_oe", 32'(uio_oe), 32'hFF);

        // Disable during OWN
        ena = 1'b0;
        tick(); check("d6_gnt_off", 32'(gnt), 0); check("d6_oe_off", 32'(uio_oe), 0);
        check("d6_out_hold", 32'(uio_out), 32'h11);
        for (int i = 0; i < 3; i++) begin
            tick(); check("d6_no_grant", 32'(gnt), 0);
        end
        ena = 1'b1; dir = '0;
        tick(); check("d6_resume", 32'(gnt), 32'h1);

        // Asynchronous reset in the middle of a drive tenure
        req = '0;
        tick();
        tick();
        req = 4'b0001; dir = 4'b0001; wdata = 32'h0000_005A;
        tick();
        tick();
        tick(); check("d5_oe_pre", 32'(uio_oe), 32'hFF); check("d5_out_pre", 32'(uio_out), 32'h5A);
        #3;
        rst = 1'b1;
        #1;
        check("d5_gnt", 32'(gnt), 0);
        check("d5_oe", 32'(uio_oe), 0);
        check("d5_out", 32'(uio_out), 0);
        check("d5_busy", 32'(busy), 0);
        tick();
        rst = 1'b0; req = '0; dir = '0; wdata = '0;

        // Round robin with tenure cap
        req = 4'b1111;
        tick();
        for (int i = 0; i < 5; i++) begin
            check("rr_owner", 32'(gnt), 32'(1 << order[i]));
            n = 0;
            while (gnt === 4'(1 << order[i]) && n < 20) begin
                n++;
                tick();
            end
            check("rr_beats", n, MAX_HOLD);
            check("rr_gap", 32'(gnt), 0);
            tick();
        end
        req = '0;
        tick();

        // Randomized traffic against the model
        for (int c = 0; c < 1500; c++) begin
            ena = ($urandom_range(0, 15) != 0);
            for (int b = 0; b < NREQ; b++) begin
                if ($urandom_range(0, 5) == 0) req[b] = ~req[b];
                if ($urandom_range(0, 15) == 0) dir[b] = ~dir[b];
                last[b] = ($urandom_range(0, 4) == 0);
            end
            wdata = $urandom;
            uio_in = 8'($urandom);
            rst = ($urandom_range(0, 299) == 0);
            tick();
        end
        rst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
